freq_gen_m: RTL and testbench

//  - Square-wave generator on one IO; the transmit counterpart of the frequency-measurement block.
//  - Emits a programmed number of periods at a programmed period, then flags done.
//  - Sits in the IO/test path so the host can drive a known frequency.
//  - That output can be looped back into the measurement block for self-test.

---
 rtl/freq_gen_pkg.sv | 25 ++
 rtl/freq_gen_phase_cnt.sv | 41 ++++
 rtl/freq_gen_m.sv | 161 ++++++++++++++++
 tb/tb_freq_gen_m.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// Shared globals for the square-wave generator and its measurement counterpart:
// logic-level constants, default widths and the generator FSM state encoding.
package freq_gen_pkg;

  // Output levels of the generated waveform
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Default widths of the generator (transmit side)
  localparam int FREQ_GEN_PER_NBIT = 32;
  localparam int FREQ_GEN_CNT_NBIT = 16;

  // Default widths of the frequency-measurement block (receive side)
  localparam int FREQ_MEAS_PER_NBIT = 32;
  localparam int FREQ_MEAS_CNT_NBIT = 16;

  // Generator FSM state encoding
  typedef enum logic [1:0] {
    FG_IDLE = 2'd0,
    FG_HI   = 2'd1,
    FG_LO   = 2'd2,
    FG_FIN  = 2'd3
  } fg_state_e;

endpackage : freq_gen_pkg

// File: rtl/freq_gen_phase_cnt.sv
// Loadable down-counter that times one phase (high or low) of the waveform.
// It counts from the loaded value down to zero and then parks at zero; the
// zero flag tells the FSM the current phase has reached its final cycle.
module freq_gen_phase_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load wins, otherwise decrement while enabled, never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : freq_gen_phase_cnt

// File: rtl/freq_gen_m.sv
// Square-wave generator: emits a programmed number of periods with programmed
// high/low phase lengths on one IO, then flags done until the next start.
// Optional feature macro FREQ_GEN_DUTY_EN: when defined, separate i_high and
// i_low phase lengths replace the single i_half (50% duty) input.
module freq_gen_m
  import freq_gen_pkg::*;
#(
  parameter int PER_NBIT = FREQ_GEN_PER_NBIT,
  parameter int CNT_NBIT = FREQ_GEN_CNT_NBIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_NBIT-1:0] i_cnt,
`ifdef FREQ_GEN_DUTY_EN
  input  logic [PER_NBIT-1:0] i_high,
  input  logic [PER_NBIT-1:0] i_low,
`else
  input  logic [PER_NBIT-1:0] i_half,
`endif
  output logic                o_io,
  output logic                busy,
  output logic                done,
  output logic [CNT_NBIT-1:0] o_sent
);

  localparam logic [PER_NBIT-1:0] PER_ONE = {{(PER_NBIT-1){1'b0}}, 1'b1};
  localparam logic [CNT_NBIT:0]   CNT_ONE = {{CNT_NBIT{1'b0}}, 1'b1};

  // Phase length minus one, with a zero length treated as one cycle
  function automatic logic [PER_NBIT-1:0] phase_m1(input logic [PER_NBIT-1:0] len);
    return (len == '0) ? '0 : (len - PER_ONE);
  endfunction

  // Phase lengths presented at the inputs (latched only on start)
  logic [PER_NBIT-1:0] hi_len_in;
  logic [PER_NBIT-1:0] lo_len_in;
`ifdef FREQ_GEN_DUTY_EN
  assign hi_len_in = i_high;
  assign lo_len_in = i_low;
`else
  assign hi_len_in = i_half;
  assign lo_len_in = i_half;
`endif

  // FSM state, latched configuration and registered outputs
  fg_state_e           state_q;
  logic [CNT_NBIT-1:0] cnt_q;
  logic [PER_NBIT-1:0] hi_m1_q;
  logic [PER_NBIT-1:0] lo_m1_q;
  logic                io_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_NBIT-1:0] sent_q;

  // Phase counter interface
  logic                pc_load;
  logic [PER_NBIT-1:0] pc_val;
  logic                pc_en;
  logic                pc_zero;

  // One extra bit so that an all-ones period count cannot overflow the compare
  logic [CNT_NBIT:0]   sent_inc;
  logic                more_periods;

  assign sent_inc     = {1'b0, sent_q} + CNT_ONE;
  assign more_periods = (sent_inc < {1'b0, cnt_q});
  assign pc_en        = (state_q == FG_HI) || (state_q == FG_LO);

  // Reload the phase counter on start and at every phase change that continues the run
  always_comb begin
    pc_load = 1'b0;
    pc_val  = '0;
    if (start) begin
      pc_load = 1'b1;
      pc_val  = phase_m1(hi_len_in);
    end else if ((state_q == FG_HI) && pc_zero) begin
      pc_load = 1'b1;
      pc_val  = lo_m1_q;
    end else if ((state_q == FG_LO) && pc_zero && more_periods) begin
      pc_load = 1'b1;
      pc_val  = hi_m1_q;
    end
  end

  freq_gen_phase_cnt #(
    .W (PER_NBIT)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (pc_val),
    .en_i       (pc_en),
    .zero_o     (pc_zero)
  );

  // Generator FSM: start (re)loads config from any state, reset aborts everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FG_IDLE;
      cnt_q   <= '0;
      hi_m1_q <= '0;
      lo_m1_q <= '0;
      io_q    <= LOW;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
    end else if (start) begin
      cnt_q   <= i_cnt;
      hi_m1_q <= phase_m1(hi_len_in);
      lo_m1_q <= phase_m1(lo_len_in);
      sent_q  <= '0;
      done_q  <= 1'b0;
      if (i_cnt == '0) begin
        // Nothing to emit: pass through FIN so done rises one cycle later
        state_q <= FG_FIN;
        io_q    <= LOW;
        busy_q  <= 1'b0;
      end else begin
        state_q <= FG_HI;
        io_q    <= HIGH;
        busy_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        FG_HI: begin
          if (pc_zero) begin
            state_q <= FG_LO;
            io_q    <= LOW;
          end
        end
        FG_LO: begin
          if (pc_zero) begin
            sent_q <= sent_inc[CNT_NBIT-1:0];
            if (more_periods) begin
              state_q <= FG_HI;
              io_q    <= HIGH;
            end else begin
              state_q <= FG_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        FG_FIN: begin
          state_q <= FG_IDLE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= FG_IDLE;
        end
      endcase
    end
  end

  assign o_io   = io_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign o_sent = sent_q;

endmodule : freq_gen_m

// File: tb/tb_freq_gen_m.sv
// Bench for freq_gen_m: a period-arithmetic reference model checked every
// cycle, plus literal waveform expectations for the directed scenarios.
module tb_freq_gen_m;

  localparam int PER_NBIT = 32;
  localparam int CNT_NBIT = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [CNT_NBIT-1:0] i_cnt = '0;
`ifdef FREQ_GEN_DUTY_EN
  logic [PER_NBIT-1:0] i_high = '0;
  logic [PER_NBIT-1:0] i_low = '0;
`else
  logic [PER_NBIT-1:0] i_half = '0;
`endif
  logic                o_io;
  logic                busy;
  logic                done;
  logic [CNT_NBIT-1:0] o_sent;

  int total = 0;
  int bad = 0;

  freq_gen_m #(
    .PER_NBIT (PER_NBIT),
    .CNT_NBIT (CNT_NBIT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .i_cnt  (i_cnt),
`ifdef FREQ_GEN_DUTY_EN
    .i_high (i_high),
    .i_low  (i_low),
`else
    .i_half (i_half),
`endif
    .o_io   (o_io),
    .busy   (busy),
    .done   (done),
    .o_sent (o_sent)
  );

  always #5 clk = ~clk;

  // Reference model: cycles elapsed since the last start plus the latched config
  bit     mdl_valid = 1'b0;
  bit     mdl_run = 1'b0;
  longint mk = 0;
  longint mcnt = 0;
  longint mh = 1;
  longint ml = 1;

  always @(posedge clk) begin
    if (rst) begin
      mdl_valid <= 1'b1;
      mdl_run   <= 1'b0;
    end else if (start) begin
      mdl_run <= 1'b1;
      mk      <= 1;
      mcnt    <= longint'(i_cnt);
`ifdef FREQ_GEN_DUTY_EN
      mh <= (i_high == '0) ? 1 : longint'(i_high);
      ml <= (i_low == '0) ? 1 : longint'(i_low);
`else
      mh <= (i_half == '0) ? 1 : longint'(i_half);
      ml <= (i_half == '0) ? 1 : longint'(i_half);
`endif
    end else if (mdl_run) begin
      mk <= mk + 1;
    end
  end

  // Expected outputs for cycle k after start: period p = (k-1)/(H+L), phase (k-1)%(H+L)
  always @(negedge clk) begin
    if (mdl_valid) begin
      bit     e_io, e_busy, e_done;
      longint e_sent, per, idx;
      e_io = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sent = 0;
      if (mdl_run) begin
        per = mh + ml;
        if (mcnt == 0) begin
          e_done = (mk >= 2);
        end else if (mk <= mcnt * per) begin
          idx    = mk - 1;
          e_io   = ((idx % per) < mh);
          e_busy = 1'b1;
          e_sent = idx / per;
        end else begin
          e_done = 1'b1;
          e_sent = mcnt;
        end
      end
      total++;
      if (o_io !== e_io || busy !== e_busy || done !== e_done ||
          o_sent !== e_sent[CNT_NBIT-1:0]) begin
        bad++;
        $display("FAIL model_cycle t=%0t got io=%b busy=%b done=%b sent=%0d want io=%b busy=%b done=%b sent=%0d",
                 $time, o_io, busy, done, o_sent, e_io, e_busy, e_done, e_sent);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end else begin
      $display("check %s ok value=%0d", name, got);
    end
  endtask

  task automatic set_half(input logic [PER_NBIT-1:0] h);
`ifdef FREQ_GEN_DUTY_EN
    i_high = h;
    i_low  = h;
`else
    i_half = h;
`endif
  endtask

  // Pulse start for one cycle; returns positioned in the first cycle after start
  task automatic do_start(input logic [PER_NBIT-1:0] h, input logic [CNT_NBIT-1:0] c);
    set_half(h);
    i_cnt = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] pat;
  int          hi_cycles;
  int          waited;
  int          held;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_io", o_io, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sent", o_sent, 0);

    // Basic run, half=3 cnt=2; inputs changed right after start must be ignored
    do_start(3, 2);
    set_half(7);
    i_cnt = 9;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      pat = {pat[30:0], o_io};
      tick();
    end
    chk("basic_wave", pat[11:0], 12'b111000111000);
    chk("basic_done", done, 1);
    chk("basic_sent", o_sent, 2);
    chk("basic_busy", busy, 0);

    // Zero count: no pulse, done two cycles after start
    do_start(3, 0);
    chk("zcnt_busy_t1", busy, 0);
    chk("zcnt_done_t1", done, 0);
    chk("zcnt_io_t1", o_io, 0);
    tick();
    chk("zcnt_done_t2", done, 1);
    chk("zcnt_busy_t2", busy, 0);

    // Zero half: 2-cycle period, 3 periods
    do_start(0, 3);
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[30:0], o_io};
      tick();
    end
    chk("zhalf_wave", pat[5:0], 6'b101010);
    chk("zhalf_done", done, 1);
    chk("zhalf_sent", o_sent, 3);

    // Restart mid-way through the 2nd high phase of a cnt=5 run
    do_start(3, 5);
    repeat (7) tick();
    chk("rst_pre_io", o_io, 1);
    chk("rst_pre_sent", o_sent, 1);
    do_start(3, 5);
    chk("restart_io", o_io, 1);
    chk("restart_sent", o_sent, 0);
    chk("restart_done", done, 0);
    hi_cycles = 0;
    waited = 0;
    while (!done && waited < 200) begin
      hi_cycles += int'(o_io);
      tick();
      waited++;
    end
    chk("restart_timeout", (waited < 200) ? 1 : 0, 1);
    chk("restart_hi_cycles", hi_cycles, 15);
    chk("restart_sent_final", o_sent, 5);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      held += int'(done);
      tick();
    end
    chk("restart_done_held", held, 5);

    // Reset during a low phase, then a normal run
    do_start(4, 3);
    repeat (5) tick();
    chk("midrst_pre_io", o_io, 0);
    chk("midrst_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_io", o_io, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sent", o_sent, 0);
    do_start(1, 2);
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      pat = {pat[30:0], o_io};
      tick();
    end
    chk("postrst_wave", pat[3:0], 4'b1010);
    chk("postrst_done", done, 1);
    chk("postrst_sent", o_sent, 2);

`ifdef FREQ_GEN_DUTY_EN
    // Asymmetric duty: 2 high + 5 low, 3 periods, measured period of 7 cycles
    i_high = 2;
    i_low  = 5;
    i_cnt  = 3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    pat = '0;
    held = -1;
    waited = -1;
    for (int i = 0; i < 21; i++) begin
      if (o_io && (i == 0 || !pat[0])) begin
        if (held < 0) held = i;
        else if (waited < 0) waited = i;
      end
      pat = {pat[30:0], o_io};
      tick();
    end
    chk("duty_wave", pat[20:0], 21'b110000011000001100000);
    chk("duty_period", waited - held, 7);
    chk("duty_done", done, 1);
    chk("duty_sent", o_sent, 3);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_freq_gen_m
